riscv_multicycle_ctrl: RTL and testbench

Control unit for the multicycle RV32I CPU, which shares one ALU and one unified instruction/data memory across cycles. A Moore main FSM sequences fetch, decode, execute, memory and writeback. An ALU decoder and instruction-type decoder produce the datapath selects each cycle. Sits beside the multicycle datapath inside the CPU top; the datapath supplies opcode/funct fields from its instruction register and the ALU Zero flag.

---
 rtl/riscv_mc_pkg.sv | 60 ++++++
 rtl/riscv_alu_decoder.sv | 40 ++++
 rtl/riscv_multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared encodings for the multicycle RV32I control unit
//
// Purpose: state encodings, opcode constants, ALUControl / ImmSrc / ALUOp codes
//          and the opcode-to-immediate-format helper.
// Ports:   none (package).
// Options: RISCV_MC_CTRL_BNE_EN enables the BNE state in the control unit.

package riscv_mc_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_BNE      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - ALUOp/funct field to ALUControl decoder
//
// Purpose: maps the FSM's ALUOp class plus instruction funct fields to the
//          3-bit ALUControl code. Shared with the single-cycle CPU.
// Ports:   alu_op[1:0]  in  00 add, 01 sub, 10 decode from funct fields
//          funct3[2:0]  in  IR[14:12]
//          funct7b5     in  IR[30]
//          op5          in  IR[5], distinguishes R-type from I-type
//          alu_control[2:0] out ALU operation select

module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for R-type; addi reuses bit 30 as immediate
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - Moore main FSM and decoders for the multicycle RV32I CPU
//
// Purpose: sequences fetch/decode/execute/memory/writeback and drives the
//          datapath selects each cycle.
// Ports:   clk, reset (sync, active-high); op, funct3, funct7b5 from the IR;
//          Zero from the ALU; PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//          ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite to the datapath;
//          state_dbg exposes the state register.
// Options: RISCV_MC_CTRL_BNE_EN adds the BNE state (op 1100011, funct3 001).

module riscv_multicycle_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state, next_state, out_state;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       branch_ne;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_JAL:            next_state = S_JAL;
`ifdef RISCV_MC_CTRL_BNE_EN
          OP_BRANCH:         next_state = (funct3 == F3_BNE) ? S_BNE : S_BEQ;
`else
          OP_BRANCH:         next_state = S_BEQ;
`endif
          // Unknown opcodes retire as NOPs; PC was already advanced in FETCH.
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // While reset is held the outputs already show FETCH, so an aborted
  // instruction cannot leave a write strobe asserted into the reset edge.
  assign out_state = reset ? S_FETCH : state;

  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    case (out_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
`ifdef RISCV_MC_CTRL_BNE_EN
      S_BNE: begin
        ALUSrcA   = 2'b10;
        alu_op    = ALUOP_SUB;
        branch_ne = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign PCWrite   = pc_update | (branch & Zero) | (branch_ne & ~Zero);
  assign ImmSrc    = imm_src_for(op);
  assign state_dbg = STATE_W'(state);

  riscv_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - self-checking bench for riscv_multicycle_ctrl
//
// Purpose: directed and randomized instructions checked cycle by cycle against
//          an instruction-level reference model.
// Ports:   none (top-level bench).
// Options: RISCV_MC_CTRL_BNE_EN selects the BNE-aware reference model.

module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alc;
    logic [1:0] imm;
    logic       rw;
  } out_t;

  riscv_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bne(input logic [6:0] o, input logic [2:0] f3);
`ifdef RISCV_MC_CTRL_BNE_EN
    return (o == 7'b1100011) && (f3 == 3'b001);
`else
    return 1'b0;
`endif
  endfunction

  // Arithmetic meaning of the instruction in its execute step.
  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Step-by-step list of FSM states an instruction walks through.
  function automatic void steps_of(input logic [6:0] o, input logic [2:0] f3, output int seq[$]);
    seq = {0, 1};
    case (o)
      7'b0000011: seq = {seq, 2, 3, 4};
      7'b0100011: seq = {seq, 2, 5};
      7'b0110011: seq = {seq, 6, 8};
      7'b0010011: seq = {seq, 7, 8};
      7'b1101111: seq = {seq, 9, 8};
      7'b1100011: seq.push_back(is_bne(o, f3) ? 11 : 10);
      default: ;
    endcase
  endfunction

  function automatic out_t expect_out(input int s, input logic [6:0] o, input logic [2:0] f3,
                                      input logic f7, input logic z);
    out_t e = '0;
    e.imm = imm_of(o);
    case (s)
      0:  begin e.irw = 1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = 1; end
      1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      3:  e.adr = 1;
      4:  begin e.rs = 2'b01; e.rw = 1; end
      5:  begin e.adr = 1; e.mw = 1; end
      6:  begin e.sa = 2'b10; e.alc = funct_alu(o, f3, f7); end
      7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alc = funct_alu(o, f3, f7); end
      8:  e.rw = 1;
      9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      10: begin e.sa = 2'b10; e.alc = 3'b001; e.pcw = z; end
      11: begin e.sa = 2'b10; e.alc = 3'b001; e.pcw = ~z; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t observed();
    return '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite};
  endfunction

  // Called just after a rising edge with the DUT in FETCH; runs up to max_steps cycles.
  task automatic run_instr(input string name, input logic [31:0] instr, input logic z,
                           input int max_steps);
    int seq[$];
    int n;
    op       = instr[6:0];
    funct3   = instr[14:12];
    funct7b5 = instr[30];
    Zero     = z;
    steps_of(op, funct3, seq);
    n = (max_steps < seq.size()) ? max_steps : seq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s state[%0d]", name, i), 32'(state_dbg), 32'(seq[i]));
      chk($sformatf("%s outputs[%0d]", name, i), 32'(observed()),
          32'(expect_out(seq[i], op, funct3, funct7b5, Zero)));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [31:0] rnd;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011, 7'b0000000};

    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'(state_dbg), 32'd0);
    chk("reset outputs", 32'(observed()), 32'(expect_out(0, op, funct3, funct7b5, Zero)));
    reset = 1'b0;
    #2;
    chk("post-reset state", 32'(state_dbg), 32'd0);
    chk("post-reset IRWrite", 32'(IRWrite), 32'd1);
    chk("post-reset PCWrite", 32'(PCWrite), 32'd1);
    chk("post-reset ALUSrcB", 32'(ALUSrcB), 32'd2);

    run_instr("lw",  32'h00802283, 1'b0, 99);
    run_instr("sw",  32'h06502423, 1'b0, 99);
    run_instr("sub", 32'h402081B3, 1'b0, 99);
    run_instr("add", 32'h002081B3, 1'b1, 99);
    run_instr("or",  32'h0020E1B3, 1'b0, 99);
    run_instr("and", 32'h0020F1B3, 1'b0, 99);
    run_instr("slt", 32'h0020A1B3, 1'b0, 99);
    run_instr("addi_b30", 32'h40008093, 1'b0, 99);
    run_instr("jal", 32'h0080006F, 1'b0, 99);
    run_instr("beq_z1", 32'h00208463, 1'b1, 99);
    run_instr("beq_z0", 32'h00208463, 1'b0, 99);
    run_instr("bne_z1", 32'h00209463, 1'b1, 99);
    run_instr("bne_z0", 32'h00209463, 1'b0, 99);
    run_instr("illegal", 32'h00000000, 1'b0, 99);

    // Abort a load in MEMREAD: FETCH outputs while reset is held, FETCH next cycle.
    run_instr("lw_abort", 32'h00802283, 1'b0, 3);
    chk("abort pre state", 32'(state_dbg), 32'd3);
    reset = 1'b1;
    #2;
    chk("abort during reset", 32'(observed()), 32'(expect_out(0, op, funct3, funct7b5, Zero)));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort next state", 32'(state_dbg), 32'd0);
    chk("abort no MemWrite", 32'(MemWrite), 32'd0);
    chk("abort no RegWrite", 32'(RegWrite), 32'd0);

    for (int k = 0; k < 60; k++) begin
      rnd = $urandom;
      rnd[6:0] = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 5) == 0) rnd[6:0] = 7'($urandom);
      run_instr($sformatf("rnd%0d_%08h", k, rnd), rnd, 1'($urandom), 99);
    end

    @(negedge clk);
    chk("final state", 32'(state_dbg), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
